commit_trace_buffer: RTL and testbench
======================================

# commit_trace_buffer

Synthesizable, parametrised commit-trace recorder for the multicore RISC-V pipeline. It watches the retire stream of every hart. It keeps a circular history of retired PC/instruction pairs for one selected hart, filtered by an address window. It freezes the history when a trigger fires: PC match, external trigger, or a per-hart hang watchdog. The frozen contents can then be drained through a pop port. It sits beside the cores in the SoC top and gives in-system visibility without a simulator.

## Interface

Parameters:
- NUM_HARTS, 2: number of monitored harts (1..8)
- DEPTH, 16: history entries; power of two, ≥2
- POST_COUNT, 4: entries captured after trigger before freezing (0..DEPTH-1)
- HANG_LIMIT, 1024: cycles without retire on a hart that raise a hang trigger

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- commit_valid  in  NUM_HARTS  per-hart retire strobe
- commit_pc  in  32*NUM_HARTS  retired PC; hart h at bits [32h+31:32h]
- commit_instr  in  32*NUM_HARTS  retired instruction word, same packing
- hart_sel  in  3  hart whose retires are recorded (values ≥NUM_HARTS record nothing)
- win_lo, win_hi  in  32  inclusive PC capture window
- filter_en  in  1  1: record only win_lo ≤ pc ≤ win_hi; 0: record all
- trig_pc  in  32  PC-match trigger value (selected hart)
- trig_pc_en  in  1  enables PC-match trigger
- trig_ext  in  1  external trigger pulse
- arm  in  1  one-cycle pulse: clear history and start capture
- rd_en  in  1  pop oldest entry (honoured only in FROZEN)
- rd_valid  out  1  rd_data valid this cycle
- rd_data  out  64  {pc, instr} of popped entry
- count  out  $clog2(DEPTH)+1  entries held
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 FROZEN
- trig_cause  out  3  sticky {hang, ext, pc_match}
- hang_hart  out  3  lowest-index hart that tripped the watchdog
- wrapped  out  1  sticky: at least one entry overwritten since arm

## Operation

- Reset: state IDLE, count 0, pointers 0, trig_cause 0, hang_hart 0, wrapped 0, rd_valid 0, rd_data 0, all watchdog counters 0.
- Record event: the recordable hart is hart_sel when hart_sel < NUM_HARTS. A record event occurs when its commit_valid is 1 and either filter_en=0 or the PC is inside the window. Window compare is unsigned.
- IDLE: no capture. arm → ARMED.
- ARMED: each record event writes at the write pointer and increments it mod DEPTH. If count==DEPTH, the oldest entry is overwritten, the read pointer advances, count stays DEPTH and wrapped is set. Any trigger → POST with post counter = POST_COUNT; if POST_COUNT=0, go straight to FROZEN.
- Trigger sources, evaluated in ARMED only:
  - pc_match: record event with pc==trig_pc while trig_pc_en=1. The matching entry is itself recorded.
  - ext: trig_ext high.
  - hang: any hart's watchdog reaches HANG_LIMIT.
  - All sources true in the same cycle set their cause bits together.
- POST: recording continues with the same wrap rules. Each record event decrements the post counter; when it reaches 0 the state becomes FROZEN. Further triggers are ignored.
- FROZEN: no writes. rd_en with count>0 pops the oldest entry: read pointer +1, count −1. rd_en with count 0 is ignored and gives rd_valid 0.
- rd_en outside FROZEN is ignored.
- arm in any state: clear count, pointers, trig_cause, wrapped, hang_hart and watchdogs, then enter ARMED. arm takes priority over a trigger or rd_en in the same cycle.
- Watchdog, per hart, running in ARMED and POST:
  - commit_valid=1 clears the counter; otherwise it increments, saturating at HANG_LIMIT.
  - The counter is cleared on arm and held at 0 in IDLE.
  - hang_hart latches on the first hang trigger only.

## Timing

- Capture: an event at edge N is visible in count after edge N.
- Trigger detection is combinational on inputs. The state changes at the same edge, and the triggering event's entry is written at that edge.
- Pop: rd_en sampled at edge N gives rd_valid/rd_data registered after edge N, valid for one cycle. Back-to-back pops are allowed every cycle.
- Hang fires at the edge where the counter increments to HANG_LIMIT, i.e. after HANG_LIMIT consecutive idle cycles.
- A simultaneous record event and pop cannot occur, because pops happen only in FROZEN.

## Test plan

- Basic capture: DEPTH=16, POST_COUNT=2, filter off, hart_sel=0, arm. Retire PCs 0x100,0x104,… (6 events), then pulse trig_ext, then 2 more → FROZEN; count=8, trig_cause=3'b010; pops return 0x100..0x11C in order, a 9th pop gives rd_valid 0.
- Wrap: DEPTH=4, POST_COUNT=0, 10 events PC 0x0..0x24, trig_pc=0x24 → FROZEN, cause 3'b001, wrapped=1, pops return 0x18,0x1C,0x20,0x24.
- Window filter: win 0x770..0x794, retire 0x760..0x7A0 step 4 → exactly 10 entries 0x770..0x794.
- Hang: NUM_HARTS=2, HANG_LIMIT=8, hart 0 retires every cycle, hart 1 stops → hang fires on the 8th idle cycle, hang_hart=1, cause 3'b100.
- Priority: arm and trig_ext in the same cycle → ARMED, trig_cause 0. rst asserted in POST → all outputs return to reset values at the next edge.
- Hart select: hart_sel=1, both harts retire distinct PCs → only hart-1 PCs recorded. hart_sel=5 → count stays 0.

Source files
------------

// File: rtl/commit_trace_if.sv
// commit_trace_if: port bundle of the commit-trace recorder.
//   master: drives the retire stream, configuration, arm/trigger controls and
//           rd_en; observes the recorder status and pop data.
//   slave : the recorder itself.
//
// Handshakes:
//   commit_valid[h] is a one-cycle strobe with no ready. The recorder never
//   back-pressures the cores, so each cycle the strobe is high counts as one
//   retire. rd_en is a pop request sampled at a clock edge. The answer comes
//   in the following cycle as rd_valid, high for exactly one cycle, with
//   rd_data. rd_valid low means nothing was popped (wrong state or empty).
interface commit_trace_if #(
  parameter int NUM_HARTS = 2,
  parameter int DEPTH     = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_HARTS-1:0]    commit_valid;
  logic [32*NUM_HARTS-1:0] commit_pc;
  logic [32*NUM_HARTS-1:0] commit_instr;
  logic [2:0]              hart_sel;
  logic [31:0]             win_lo;
  logic [31:0]             win_hi;
  logic                    filter_en;
  logic [31:0]             trig_pc;
  logic                    trig_pc_en;
  logic                    trig_ext;
  logic                    arm;
  logic                    rd_en;

  logic                    rd_valid;
  logic [63:0]             rd_data;
  logic [CW-1:0]           count;
  logic [1:0]              state;
  logic [2:0]              trig_cause;
  logic [2:0]              hang_hart;
  logic                    wrapped;

  modport master (
    output commit_valid, commit_pc, commit_instr, hart_sel, win_lo, win_hi,
           filter_en, trig_pc, trig_pc_en, trig_ext, arm, rd_en,
    input  rd_valid, rd_data, count, state, trig_cause, hang_hart, wrapped
  );

  modport slave (
    input  commit_valid, commit_pc, commit_instr, hart_sel, win_lo, win_hi,
           filter_en, trig_pc, trig_pc_en, trig_ext, arm, rd_en,
    output rd_valid, rd_data, count, state, trig_cause, hang_hart, wrapped
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: circular history of retired {pc, instr} pairs for one
// selected hart. The history freezes after a trigger (PC match, external
// pulse or per-hart hang watchdog) plus POST_COUNT further entries. It can
// then be drained oldest-first.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : commit_trace_if.slave. Carries the retire stream, window and
//              trigger setup, arm, rd_en, and the outputs rd_valid, rd_data,
//              count, state, trig_cause, hang_hart and wrapped.
module commit_trace_buffer #(
  parameter int NUM_HARTS  = 2,
  parameter int DEPTH      = 16,
  parameter int POST_COUNT = 4,
  parameter int HANG_LIMIT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  commit_trace_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(HANG_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_POST   = 2'd2,
    S_FROZEN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [63:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [AW-1:0]   post_q;
  logic [2:0]      cause_q;
  logic [2:0]      hang_hart_q;
  logic            wrapped_q;
  logic            rd_valid_q;
  logic [63:0]     rd_data_q;
  logic [WW-1:0]   wd_q [NUM_HARTS];

  // Selected-hart retire; stays invalid when hart_sel is out of range.
  logic        sel_valid;
  logic [31:0] sel_pc, sel_instr;
  always_comb begin
    sel_valid = 1'b0;
    sel_pc    = '0;
    sel_instr = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (bus.hart_sel == 3'(h)) begin
        sel_valid = bus.commit_valid[h];
        sel_pc    = bus.commit_pc[32*h +: 32];
        sel_instr = bus.commit_instr[32*h +: 32];
      end
    end
  end

  logic in_win, rec_ev;
  assign in_win = (sel_pc >= bus.win_lo) && (sel_pc <= bus.win_hi);
  assign rec_ev = sel_valid && (!bus.filter_en || in_win);

  // A hart trips on the edge its idle counter steps from HANG_LIMIT-1 to
  // HANG_LIMIT, which happens on the HANG_LIMIT-th consecutive idle cycle.
  logic [NUM_HARTS-1:0] hang_hit;
  logic                 hang_any;
  logic [2:0]           hang_lo;
  always_comb begin
    hang_hit = '0;
    hang_any = 1'b0;
    hang_lo  = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      hang_hit[h] = !bus.commit_valid[h] && (wd_q[h] == WW'(HANG_LIMIT - 1));
    end
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (hang_hit[h]) begin
        hang_any = 1'b1;
        hang_lo  = 3'(h);
      end
    end
  end

  logic pc_hit, trig_any, capturing, do_write, do_pop;
  assign pc_hit    = rec_ev && bus.trig_pc_en && (sel_pc == bus.trig_pc);
  assign trig_any  = pc_hit || bus.trig_ext || hang_any;
  assign capturing = (state_q == S_ARMED) || (state_q == S_POST);
  assign do_write  = capturing && rec_ev && !bus.arm;
  assign do_pop    = (state_q == S_FROZEN) && bus.rd_en && (count_q != '0) && !bus.arm;

  // FSM next state; arm wins over everything else.
  always_comb begin
    state_d = state_q;
    if (bus.arm) begin
      state_d = S_ARMED;
    end else begin
      case (state_q)
        S_ARMED: if (trig_any) state_d = (POST_COUNT == 0) ? S_FROZEN : S_POST;
        S_POST:  if (rec_ev && post_q == AW'(1)) state_d = S_FROZEN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // History storage needs no reset; count and pointers define what is live.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_q] <= {sel_pc, sel_instr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      post_q      <= '0;
      cause_q     <= '0;
      hang_hart_q <= '0;
      wrapped_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      if (bus.arm) begin
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        count_q     <= '0;
        post_q      <= '0;
        cause_q     <= '0;
        hang_hart_q <= '0;
        wrapped_q   <= 1'b0;
      end else begin
        if (do_write) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
          // Full: the new entry replaces the oldest, so the read side moves.
          if (count_q == CW'(DEPTH)) begin
            rd_ptr_q  <= rd_ptr_q + AW'(1);
            wrapped_q <= 1'b1;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        if (do_pop) begin
          rd_valid_q <= 1'b1;
          rd_data_q  <= mem[rd_ptr_q];
          rd_ptr_q   <= rd_ptr_q + AW'(1);
          count_q    <= count_q - CW'(1);
        end
        // Triggers are only looked at in ARMED, so the cause bits and
        // hang_hart latch once per arm.
        if (state_q == S_ARMED && trig_any) begin
          cause_q <= {hang_any, bus.trig_ext, pc_hit};
          post_q  <= AW'(POST_COUNT);
          if (hang_any) hang_hart_q <= hang_lo;
        end else if (state_q == S_POST && rec_ev) begin
          post_q <= post_q - AW'(1);
        end
      end
    end
  end

  // Per-hart idle watchdogs: zero in IDLE, run while capturing, hold in FROZEN.
  always_ff @(posedge clk) begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (rst || bus.arm || state_q == S_IDLE) begin
        wd_q[h] <= '0;
      end else if (capturing) begin
        if (bus.commit_valid[h])                wd_q[h] <= '0;
        else if (wd_q[h] != WW'(HANG_LIMIT))    wd_q[h] <= wd_q[h] + WW'(1);
      end
    end
  end

  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.count      = count_q;
  assign bus.state      = state_q;
  assign bus.trig_cause = cause_q;
  assign bus.hang_hart  = hang_hart_q;
  assign bus.wrapped    = wrapped_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;
  localparam int NH    = 2;
  localparam int DEPTH = 16;
  localparam int POSTC = 2;
  localparam int HL    = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  commit_trace_if #(.NUM_HARTS(NH), .DEPTH(DEPTH)) bus ();

  commit_trace_buffer #(
    .NUM_HARTS(NH), .DEPTH(DEPTH), .POST_COUNT(POSTC), .HANG_LIMIT(HL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  logic [63:0] exp_q[$];
  int          m_state;     // 0 idle, 1 armed, 2 post, 3 frozen
  int          m_post;
  int          m_wd [NH];
  logic [2:0]  m_cause;
  logic [2:0]  m_hh;
  logic        m_wrapped;
  logic        m_rdv;
  logic [63:0] m_rdd;
  bit          model_live = 0;

  always @(posedge clk) begin
    int hs;
    bit rec, pcm, hang;
    logic [31:0] pc, ins;
    logic [2:0] lowest;
    if (rst) begin
      model_live = 1;
      exp_q.delete();
      m_state = 0; m_post = 0; m_cause = 0; m_hh = 0; m_wrapped = 0;
      m_rdv = 0; m_rdd = 0;
      for (int h = 0; h < NH; h++) m_wd[h] = 0;
    end else if (model_live) begin
      m_rdv = 0;
      if (bus.arm) begin
        exp_q.delete();
        m_state = 1; m_cause = 0; m_hh = 0; m_wrapped = 0;
        for (int h = 0; h < NH; h++) m_wd[h] = 0;
      end else begin
        hs  = int'(bus.hart_sel);
        rec = 0; pc = 0; ins = 0;
        if (hs < NH) begin
          pc  = bus.commit_pc[32*hs +: 32];
          ins = bus.commit_instr[32*hs +: 32];
          rec = bus.commit_valid[hs] && (!bus.filter_en || (pc >= bus.win_lo && pc <= bus.win_hi));
        end
        hang = 0; lowest = 0;
        if (m_state == 1 || m_state == 2) begin
          for (int h = NH - 1; h >= 0; h--) begin
            int nw;
            nw = bus.commit_valid[h] ? 0 : ((m_wd[h] + 1 > HL) ? HL : m_wd[h] + 1);
            if (nw == HL && m_wd[h] != HL) begin hang = 1; lowest = 3'(h); end
            m_wd[h] = nw;
          end
        end
        if (m_state == 1 || m_state == 2) begin
          if (rec) begin
            if (exp_q.size() == DEPTH) begin void'(exp_q.pop_front()); m_wrapped = 1; end
            exp_q.push_back({pc, ins});
          end
        end
        if (m_state == 1) begin
          pcm = rec && bus.trig_pc_en && (pc == bus.trig_pc);
          if (pcm || bus.trig_ext || hang) begin
            m_cause = {hang, bus.trig_ext, pcm};
            if (hang) m_hh = lowest;
            m_post  = POSTC;
            m_state = (POSTC == 0) ? 3 : 2;
          end
        end else if (m_state == 2) begin
          if (rec) begin
            m_post--;
            if (m_post == 0) m_state = 3;
          end
        end else if (m_state == 3) begin
          if (bus.rd_en && exp_q.size() > 0) begin
            m_rdd = exp_q.pop_front();
            m_rdv = 1;
          end
        end
      end
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (model_live) begin
      check("state", 64'(bus.state), 64'(m_state));
      check("count", 64'(bus.count), 64'(exp_q.size()));
      check("trig_cause", 64'(bus.trig_cause), 64'(m_cause));
      check("hang_hart", 64'(bus.hang_hart), 64'(m_hh));
      check("wrapped", 64'(bus.wrapped), 64'(m_wrapped));
      check("rd_valid", 64'(bus.rd_valid), 64'(m_rdv));
      if (m_rdv) check("rd_data", bus.rd_data, m_rdd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v0, input logic [31:0] pc0, input bit v1, input logic [31:0] pc1);
    bus.commit_valid = {v1, v0};
    bus.commit_pc    = {pc1, pc0};
    bus.commit_instr = {~pc1, ~pc0};
  endtask

  task automatic do_arm();
    drive(1, 32'h0, 1, 32'h0);
    bus.arm = 1; cyc(); bus.arm = 0;
  endtask

  task automatic pop_lit(input string name, input logic [31:0] exp_pc);
    bus.rd_en = 1; cyc(); bus.rd_en = 0;
    check({name, "_valid"}, 64'(bus.rd_valid), 64'd1);
    check(name, bus.rd_data, {exp_pc, ~exp_pc});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 64'(bus.state), 64'd0);
    check({tag, "_count"}, 64'(bus.count), 64'd0);
    check({tag, "_cause"}, 64'(bus.trig_cause), 64'd0);
    check({tag, "_hang_hart"}, 64'(bus.hang_hart), 64'd0);
    check({tag, "_wrapped"}, 64'(bus.wrapped), 64'd0);
    check({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'd0);
    check({tag, "_rd_data"}, bus.rd_data, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1;
    bus.arm = 0; bus.rd_en = 0; bus.trig_ext = 0; bus.trig_pc_en = 0; bus.trig_pc = 0;
    bus.hart_sel = 0; bus.filter_en = 0; bus.win_lo = 0; bus.win_hi = 0;
    drive(0, 0, 0, 0);
    repeat (3) cyc();
    check_reset_values("reset");
    rst = 0;
    cyc();

    // Basic capture: 6 events, ext trigger, 2 more.
    do_arm();
    check("basic_armed", 64'(bus.state), 64'd1);
    for (int i = 0; i < 6; i++) begin drive(1, 32'h100 + 4*i, 1, 32'h9000); cyc(); end
    drive(0, 0, 1, 32'h9000); bus.trig_ext = 1; cyc(); bus.trig_ext = 0;
    check("basic_post", 64'(bus.state), 64'd2);
    for (int i = 6; i < 8; i++) begin drive(1, 32'h100 + 4*i, 1, 32'h9000); cyc(); end
    drive(0, 0, 0, 0);
    check("basic_frozen", 64'(bus.state), 64'd3);
    check("basic_count", 64'(bus.count), 64'd8);
    check("basic_model_count", 64'(exp_q.size()), 64'd8);
    check("basic_cause", 64'(bus.trig_cause), 64'b010);
    for (int i = 0; i < 8; i++) pop_lit($sformatf("basic_pop%0d", i), 32'h100 + 4*i);
    bus.rd_en = 1; cyc(); bus.rd_en = 0;
    check("basic_pop_empty", 64'(bus.rd_valid), 64'd0);

    // Wrap: 20 events with PC match on the last, then 2 post events.
    bus.trig_pc = 32'h4C; bus.trig_pc_en = 1;
    do_arm();
    for (int i = 0; i < 22; i++) begin drive(1, 4*i, 1, 32'h9000); cyc(); end
    drive(0, 0, 0, 0); bus.trig_pc_en = 0;
    check("wrap_frozen", 64'(bus.state), 64'd3);
    check("wrap_cause", 64'(bus.trig_cause), 64'b001);
    check("wrap_wrapped", 64'(bus.wrapped), 64'd1);
    check("wrap_count", 64'(bus.count), 64'd16);
    pop_lit("wrap_pop0", 32'h18);
    pop_lit("wrap_pop1", 32'h1C);

    // Window filter.
    bus.filter_en = 1; bus.win_lo = 32'h770; bus.win_hi = 32'h794;
    do_arm();
    for (int p = 32'h760; p <= 32'h7A0; p += 4) begin drive(1, p, 1, 32'h9000); cyc(); end
    check("win_count", 64'(bus.count), 64'd10);
    drive(0, 0, 1, 32'h9000); bus.trig_ext = 1; cyc(); bus.trig_ext = 0;
    for (int i = 0; i < 2; i++) begin drive(1, 32'h770 + 4*i, 1, 32'h9000); cyc(); end
    drive(0, 0, 0, 0); bus.filter_en = 0;
    check("win_frozen", 64'(bus.state), 64'd3);
    pop_lit("win_pop0", 32'h770);

    // Hang on hart 1.
    do_arm();
    for (int i = 0; i < 7; i++) begin drive(1, 32'h200 + 4*i, 0, 0); cyc(); end
    check("hang_not_yet", 64'(bus.state), 64'd1);
    drive(1, 32'h21C, 0, 0); cyc();
    check("hang_post", 64'(bus.state), 64'd2);
    check("hang_cause", 64'(bus.trig_cause), 64'b100);
    check("hang_hart", 64'(bus.hang_hart), 64'd1);
    for (int i = 0; i < 2; i++) begin drive(1, 32'h220 + 4*i, 0, 0); cyc(); end
    check("hang_frozen", 64'(bus.state), 64'd3);

    // Priority: arm with trig_ext, then reset during POST.
    drive(1, 32'h300, 1, 32'h9000);
    bus.arm = 1; bus.trig_ext = 1; cyc(); bus.arm = 0; bus.trig_ext = 0;
    check("prio_armed", 64'(bus.state), 64'd1);
    check("prio_cause", 64'(bus.trig_cause), 64'd0);
    bus.trig_ext = 1; cyc(); bus.trig_ext = 0;
    check("prio_post", 64'(bus.state), 64'd2);
    rst = 1; cyc(); rst = 0;
    check_reset_values("rst_in_post");

    // Hart select.
    bus.hart_sel = 1;
    do_arm();
    for (int i = 0; i < 3; i++) begin drive(1, 32'hA00 + 4*i, 1, 32'hB00 + 4*i); cyc(); end
    check("sel1_count", 64'(bus.count), 64'd3);
    bus.trig_ext = 1; drive(1, 32'hA0C, 1, 32'hB0C); cyc(); bus.trig_ext = 0;
    for (int i = 4; i < 6; i++) begin drive(1, 32'hA00 + 4*i, 1, 32'hB00 + 4*i); cyc(); end
    drive(0, 0, 0, 0);
    check("sel1_count_frozen", 64'(bus.count), 64'd6);
    pop_lit("sel1_pop0", 32'hB00);
    bus.hart_sel = 5;
    do_arm();
    for (int i = 0; i < 5; i++) begin drive(1, 32'hA00 + 4*i, 1, 32'hB00 + 4*i); cyc(); end
    check("sel5_count", 64'(bus.count), 64'd0);
    bus.hart_sel = 0;

    // Randomized phase against the model.
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 399) == 0);
      bus.arm      = ($urandom_range(0, 59) == 0);
      bus.trig_ext = ($urandom_range(0, 49) == 0);
      bus.rd_en    = $urandom_range(0, 1);
      if ($urandom_range(0, 99) == 0) bus.hart_sel = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) bus.filter_en = $urandom_range(0, 1);
      if ($urandom_range(0, 49) == 0) begin
        bus.trig_pc    = 32'h0C0 + 4 * $urandom_range(0, 64);
        bus.trig_pc_en = ($urandom_range(0, 3) == 0);
      end
      bus.win_lo = 32'h100; bus.win_hi = 32'h180;
      for (int h = 0; h < NH; h++) begin
        bus.commit_valid[h]         = ($urandom_range(0, 9) < 6);
        bus.commit_pc[32*h +: 32]    = 32'h0C0 + 4 * $urandom_range(0, 64);
        bus.commit_instr[32*h +: 32] = $urandom;
      end
      cyc();
    end
    rst = 0; bus.arm = 0; bus.trig_ext = 0; bus.rd_en = 0;
    drive(0, 0, 0, 0);
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
